ct_ebiu_cawt_ctrl: RTL and testbench
====================================

Name: ct_ebiu_cawt_ctrl

Overview:
Allocation and retirement controller for the EBIU CA write table (CAWT), an array of ENTRY non-cacheable write tracking entries.
- Accepts non-cacheable write requests and picks a free entry; the entry index is used as the AXI AW ID.
- Retires entries on B responses.
- Stalls same-index writes, CA reads and snoops that hit a live entry.
- Runs a sync/drain sequence for fence operations.

Parameters:
ENTRY, 8, number of CAWT entries (power of 2, 2..16)
IDW, 3, entry index width, equal to log2(ENTRY)

Ports:
forever_cpuclk  in  1  single clock
cpurst  in  1  asynchronous active-high reset
wr_req_vld  in  1  non-cacheable write request
wr_req_rdy  out  1  request accepted this cycle when high together with wr_req_vld
wr_req_id  out  IDW  allocated entry index, valid when wr_req_vld && wr_req_rdy
cawt_vld  in  ENTRY  per-entry valid (cawt_vld_x)
ca_wr_addr_hit_cawt  in  ENTRY  per-entry write-index hit
ca_rd_addr_hit_cawt  in  ENTRY  per-entry read-index hit
snb0_snpext_addr_hit_cawt  in  ENTRY  snoop buffer 0 index hit
snb1_snpext_addr_hit_cawt  in  ENTRY  snoop buffer 1 index hit
cawt_create_en  out  ENTRY  one-hot create strobe to entries
cawt_create_dp_en  out  ENTRY  one-hot datapath capture strobe, identical to cawt_create_en
ebiu_b_vld  in  1  write response valid
ebiu_b_id  in  IDW  write response ID
cawt_pop_en  out  ENTRY  one-hot pop strobe
ca_rd_stall  out  1  CA read must wait
snb0_snpext_stall  out  1  snoop 0 must wait
snb1_snpext_stall  out  1  snoop 1 must wait
sync_req  in  1  level request to drain the CAWT
sync_done  out  1  one-cycle pulse when the drain is complete
cawt_full  out  1  all entries occupied
cawt_empty  out  1  no entries occupied

Behaviour:
- Reset (cpurst high, asynchronous):
  - cnt=0, state=IDLE.
  - Outputs: cawt_empty=1, cawt_full=0, sync_done=0, all strobes 0.
- Free vector = ~cawt_vld. The alloc index is the lowest-numbered free bit (priority encoder).
- wr_req_rdy = (state==IDLE) && !cawt_full && !(|ca_wr_addr_hit_cawt). It is combinational with zero latency.
- Write accept (wr_req_vld && wr_req_rdy):
  - cawt_create_en and cawt_create_dp_en are one-hot at the alloc index in the same cycle.
  - wr_req_id equals the alloc index.
  - The entry becomes valid the next cycle.
- Pop: ebiu_b_vld with cawt_vld[ebiu_b_id]=1 sets cawt_pop_en[ebiu_b_id] in the same cycle.
  - A response to an invalid entry is ignored: no pop, no cnt change.
- Create and pop in the same cycle never target the same entry, because a popped entry is valid and so cannot be the alloc index.
- cnt (IDW+1 bits):
  - +1 on create only; -1 on pop only; unchanged on both or neither.
  - It never wraps; over/underflow is unreachable by construction.
  - cawt_full = (cnt==ENTRY); cawt_empty = (cnt==0).
- Stalls are combinational ORs: ca_rd_stall = |ca_rd_addr_hit_cawt; snbN_snpext_stall = |snbN_snpext_addr_hit_cawt.
- Sync FSM:
  - IDLE -> DRAIN when sync_req=1. New writes are blocked from that cycle (wr_req_rdy=0).
  - DRAIN -> DONE when cnt==0; if already empty, this happens on the next cycle.
  - DONE: sync_done=1 for one cycle, then -> WAIT.
  - WAIT -> IDLE when sync_req=0. wr_req_rdy stays 0 in WAIT.
  - Pops continue in every state.
- Reset mid-operation: the FSM returns to IDLE and cnt clears. Entries are reset by the same reset.

Optional Feature:
EBIU_CAWT_SYNC_TIMEOUT_EN
- Defined:
  - A 10-bit counter clears on DRAIN entry and increments each DRAIN cycle.
  - On reaching 1023 it asserts extra output sync_timeout (1 bit, one-cycle pulse) and the FSM goes to DONE. sync_done pulses as normal.
  - The counter resets to 0.
- Undefined: no counter, no sync_timeout port; DRAIN waits indefinitely.

Test Plan:
- After reset, 8 back-to-back writes with no hits -> wr_req_id 0..7 in order; cawt_full=1 after the 8th; 9th request sees wr_req_rdy=0.
- Full table, B response id=3 -> cawt_pop_en=8'b0000_1000; next cycle the write is accepted with wr_req_id=3 and cnt stays 8.
- Same cycle: create to entry 0 and B response for entry 5 (cnt=4) -> cawt_create_en[0]=1, cawt_pop_en[5]=1, cnt stays 4.
- ca_wr_addr_hit_cawt=8'h04 with wr_req_vld -> wr_req_rdy=0, no create; ca_rd_addr_hit_cawt=8'h04 -> ca_rd_stall=1; snb1 hit -> snb1_snpext_stall=1 only.
- cnt=2, sync_req=1 -> wr_req_rdy=0; after both B responses sync_done pulses one cycle; wr_req_rdy returns the cycle after sync_req drops.
- B response with id=6 while cawt_vld[6]=0 -> cawt_pop_en=0, cnt unchanged; with EBIU_CAWT_SYNC_TIMEOUT_EN and a response never returned, sync_timeout pulses 1023 cycles after DRAIN entry.

Source files
------------

// File: rtl/ct_ebiu_cawt_ctrl_if.sv
// ct_ebiu_cawt_ctrl_if: request, response, hit and status signals between the
// CAWT allocation controller (slave side) and its environment (master side).
// Optional port sync_timeout exists only when EBIU_CAWT_SYNC_TIMEOUT_EN is defined.
interface ct_ebiu_cawt_ctrl_if #(
    parameter int ENTRY = 8,
    parameter int IDW   = 3
);
    logic             wr_req_vld;
    logic             wr_req_rdy;
    logic [IDW-1:0]   wr_req_id;
    logic [ENTRY-1:0] cawt_vld;
    logic [ENTRY-1:0] ca_wr_addr_hit_cawt;
    logic [ENTRY-1:0] ca_rd_addr_hit_cawt;
    logic [ENTRY-1:0] snb0_snpext_addr_hit_cawt;
    logic [ENTRY-1:0] snb1_snpext_addr_hit_cawt;
    logic [ENTRY-1:0] cawt_create_en;
    logic [ENTRY-1:0] cawt_create_dp_en;
    logic             ebiu_b_vld;
    logic [IDW-1:0]   ebiu_b_id;
    logic [ENTRY-1:0] cawt_pop_en;
    logic             ca_rd_stall;
    logic             snb0_snpext_stall;
    logic             snb1_snpext_stall;
    logic             sync_req;
    logic             sync_done;
    logic             cawt_full;
    logic             cawt_empty;
`ifdef EBIU_CAWT_SYNC_TIMEOUT_EN
    logic             sync_timeout;
`endif

    // Environment side: drives requests, entry state and hits.
    modport master (
`ifdef EBIU_CAWT_SYNC_TIMEOUT_EN
        input  sync_timeout,
`endif
        output wr_req_vld, cawt_vld, ca_wr_addr_hit_cawt, ca_rd_addr_hit_cawt,
               snb0_snpext_addr_hit_cawt, snb1_snpext_addr_hit_cawt,
               ebiu_b_vld, ebiu_b_id, sync_req,
        input  wr_req_rdy, wr_req_id, cawt_create_en, cawt_create_dp_en,
               cawt_pop_en, ca_rd_stall, snb0_snpext_stall, snb1_snpext_stall,
               sync_done, cawt_full, cawt_empty
    );

    // Controller side.
    modport slave (
`ifdef EBIU_CAWT_SYNC_TIMEOUT_EN
        output sync_timeout,
`endif
        input  wr_req_vld, cawt_vld, ca_wr_addr_hit_cawt, ca_rd_addr_hit_cawt,
               snb0_snpext_addr_hit_cawt, snb1_snpext_addr_hit_cawt,
               ebiu_b_vld, ebiu_b_id, sync_req,
        output wr_req_rdy, wr_req_id, cawt_create_en, cawt_create_dp_en,
               cawt_pop_en, ca_rd_stall, snb0_snpext_stall, snb1_snpext_stall,
               sync_done, cawt_full, cawt_empty
    );
endinterface

// File: rtl/ct_ebiu_cawt_ctrl.sv
// ct_ebiu_cawt_ctrl: allocation/retirement controller for the EBIU CA write
// table. Picks the lowest free entry for each accepted non-cacheable write
// (the index doubles as the AXI AW ID), retires entries on B responses,
// raises stalls on live-entry hits and runs the fence sync/drain sequence.
// Optional feature macro: EBIU_CAWT_SYNC_TIMEOUT_EN (10-bit drain timeout
// with an extra sync_timeout pulse output).
module ct_ebiu_cawt_ctrl #(
    parameter int ENTRY = 8,
    parameter int IDW   = 3
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    ct_ebiu_cawt_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } state_e;

    localparam logic [IDW:0] CNT_FULL = (IDW + 1)'(ENTRY);
    localparam logic [IDW:0] CNT_ONE  = (IDW + 1)'(1);

    state_e           state_q, state_d;
    logic [IDW:0]     cnt_q, cnt_d;
    logic [ENTRY-1:0] free_vec;
    logic [IDW-1:0]   alloc_idx;
    logic [ENTRY-1:0] create_vec;
    logic [ENTRY-1:0] pop_vec;
    logic             full;
    logic             empty;
    logic             accept_open;
    logic             req_rdy;
    logic             wr_acc;
    logic             pop_hit;
    logic             tmo_hit;

    assign free_vec = ~bus.cawt_vld;
    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign req_rdy  = accept_open && !full && !(|bus.ca_wr_addr_hit_cawt);
    assign wr_acc   = bus.wr_req_vld && req_rdy;
    // A response naming an entry that is not live is dropped.
    assign pop_hit  = bus.ebiu_b_vld && bus.cawt_vld[bus.ebiu_b_id];

    // Priority encoder: lowest-numbered free entry wins.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        alloc_idx = '0;
        for (int i = ENTRY - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_idx = IDW'(i);
        end
    end

    // One-hot create and pop strobes; a popped entry is live so it never equals alloc_idx.
    always_comb begin
        create_vec = '0;
        pop_vec    = '0;
        if (wr_acc)  create_vec[alloc_idx]     = 1'b1;
        if (pop_hit) pop_vec[bus.ebiu_b_id]    = 1'b1;
    end

    // Occupancy count: +1 on create only, -1 on pop only.
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_acc, pop_hit})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Occupancy count and FSM state registers.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (cpurst) begin
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

`ifdef EBIU_CAWT_SYNC_TIMEOUT_EN
    logic [9:0] tmo_cnt_q, tmo_cnt_d;

    // Timeout fires only if the table has not drained by the 1023rd DRAIN cycle.
    assign tmo_hit          = (state_q == DRAIN) && (tmo_cnt_q == 10'd1023) && !empty;
    assign bus.sync_timeout = tmo_hit;

    // Count DRAIN cycles; held at zero outside DRAIN so it is clear on entry.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == DRAIN) && (state_d == DRAIN)) tmo_cnt_d = tmo_cnt_q + 10'd1;
    end

    // Drain timeout counter register.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Sync FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.sync_req)      state_d = DRAIN;
            DRAIN:   if (empty || tmo_hit)  state_d = DONE;
            DONE:                           state_d = WAIT;
            WAIT:    if (!bus.sync_req)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Sync FSM outputs: writes only admitted in IDLE, done pulse in DONE.
    always_comb begin
        accept_open   = (state_q == IDLE);
        bus.sync_done = (state_q == DONE);
    end

    assign bus.wr_req_rdy        = req_rdy;
    assign bus.wr_req_id         = alloc_idx;
    assign bus.cawt_create_en    = create_vec;
    assign bus.cawt_create_dp_en = create_vec;
    assign bus.cawt_pop_en       = pop_vec;
    assign bus.cawt_full         = full;
    assign bus.cawt_empty        = empty;
    assign bus.ca_rd_stall       = |bus.ca_rd_addr_hit_cawt;
    assign bus.snb0_snpext_stall = |bus.snb0_snpext_addr_hit_cawt;
    assign bus.snb1_snpext_stall = |bus.snb1_snpext_addr_hit_cawt;

endmodule

// File: tb/tb_ct_ebiu_cawt_ctrl.sv
// tb_ct_ebiu_cawt_ctrl: scoreboard bench for ct_ebiu_cawt_ctrl. Expected
// create IDs and pop masks are queued when stimulus is driven and consumed
// when the DUT strobes; scenario tasks check status outputs inline.
module tb_ct_ebiu_cawt_ctrl;
    localparam int ENTRY = 8;
    localparam int IDW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   exp_id_q[$];
    logic [ENTRY-1:0] exp_pop_q[$];
    logic [ENTRY-1:0] ent_vld;

    always #5 clk = ~clk;

    ct_ebiu_cawt_ctrl_if #(.ENTRY(ENTRY), .IDW(IDW)) bus ();

    ct_ebiu_cawt_ctrl #(.ENTRY(ENTRY), .IDW(IDW)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus)
    );

    // Entry array model: valid on create, cleared on pop, reset with the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ent_vld <= '0;
        else     ent_vld <= (ent_vld | bus.cawt_create_en) & ~bus.cawt_pop_en;
    end
    assign bus.cawt_vld = ent_vld;

    task automatic idle_inputs();
        bus.wr_req_vld                = 1'b0;
        bus.ebiu_b_vld                = 1'b0;
        bus.ebiu_b_id                 = '0;
        bus.ca_wr_addr_hit_cawt       = '0;
        bus.ca_rd_addr_hit_cawt       = '0;
        bus.snb0_snpext_addr_hit_cawt = '0;
        bus.snb1_snpext_addr_hit_cawt = '0;
    endtask

    // Scoreboard consumer: compares strobes against queued expectations.
    task automatic monitor();
        logic [ENTRY-1:0] exp_mask;
        int e;
        checks++;
        if (bus.wr_req_vld && bus.wr_req_rdy) begin
            if (exp_id_q.size() == 0) begin
                failures++;
                $display("FAIL accept_unexpected: got id=%0d, required no accept", bus.wr_req_id);
            end else begin
                e = exp_id_q.pop_front();
                exp_mask = ENTRY'(1) << e;
                if (bus.wr_req_id !== IDW'(e) || bus.cawt_create_en !== exp_mask ||
                    bus.cawt_create_dp_en !== exp_mask) begin
                    failures++;
                    $display("FAIL create: got id=%0d en=%b dp=%b, required id=%0d en=%b",
                             bus.wr_req_id, bus.cawt_create_en, bus.cawt_create_dp_en, e, exp_mask);
                end
            end
        end else if (bus.cawt_create_en !== '0 || bus.cawt_create_dp_en !== '0) begin
            failures++;
            $display("FAIL create_idle: got en=%b dp=%b, required 0",
                     bus.cawt_create_en, bus.cawt_create_dp_en);
        end
        checks++;
        if (bus.ebiu_b_vld) begin
            if (exp_pop_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got pop=%b, required no response", bus.cawt_pop_en);
            end else begin
                exp_mask = exp_pop_q.pop_front();
                if (bus.cawt_pop_en !== exp_mask) begin
                    failures++;
                    $display("FAIL pop: got %b, required %b", bus.cawt_pop_en, exp_mask);
                end
            end
        end else if (bus.cawt_pop_en !== '0) begin
            failures++;
            $display("FAIL pop_idle: got %b, required 0", bus.cawt_pop_en);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int id);
        idle_inputs();
        bus.wr_req_vld = 1'b1;
        exp_id_q.push_back(id);
        settle();
        advance();
        idle_inputs();
    endtask

    // Drive one B response, then report cawt_empty one cycle later.
    task automatic do_pop(input int id, input logic [ENTRY-1:0] mask, input logic exp_empty);
        idle_inputs();
        bus.ebiu_b_vld = 1'b1;
        bus.ebiu_b_id  = IDW'(id);
        exp_pop_q.push_back(mask);
        settle();
        advance();
        idle_inputs();
        settle();
        checks++;
        if (bus.cawt_empty !== exp_empty) begin
            failures++;
            $display("FAIL empty_after_pop%0d: got %b, required %b", id, bus.cawt_empty, exp_empty);
        end
        advance();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.sync_req = 1'b0;
        #12;
        checks++;
        if (bus.cawt_empty !== 1'b1 || bus.cawt_full !== 1'b0 || bus.sync_done !== 1'b0 ||
            bus.cawt_create_en !== '0 || bus.cawt_pop_en !== '0) begin
            failures++;
            $display("FAIL reset_state: got empty=%b full=%b done=%b cre=%b pop=%b, required 1 0 0 0 0",
                     bus.cawt_empty, bus.cawt_full, bus.sync_done, bus.cawt_create_en, bus.cawt_pop_en);
        end
        @(negedge clk);
        rst = 1'b0;
        advance();
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy: got %b, required 1", bus.wr_req_rdy);
        end
        advance();
    endtask

    task automatic test_fill();
        for (int i = 0; i < ENTRY; i++) begin
            idle_inputs();
            bus.wr_req_vld = 1'b1;
            exp_id_q.push_back(i);
            settle();
            checks++;
            if (bus.wr_req_rdy !== 1'b1) begin
                failures++;
                $display("FAIL fill_rdy%0d: got %b, required 1", i, bus.wr_req_rdy);
            end
            advance();
        end
        bus.wr_req_vld = 1'b1;
        settle();
        checks++;
        if (bus.cawt_full !== 1'b1 || bus.wr_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got full=%b rdy=%b, required full=1 rdy=0",
                     bus.cawt_full, bus.wr_req_rdy);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_pop_refill();
        bus.ebiu_b_vld = 1'b1;
        bus.ebiu_b_id  = 3'd3;
        exp_pop_q.push_back(8'b0000_1000);
        settle();
        advance();
        idle_inputs();
        bus.wr_req_vld = 1'b1;
        exp_id_q.push_back(3);
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b1 || bus.cawt_full !== 1'b0) begin
            failures++;
            $display("FAIL refill_rdy: got rdy=%b full=%b, required rdy=1 full=0",
                     bus.wr_req_rdy, bus.cawt_full);
        end
        advance();
        idle_inputs();
        settle();
        checks++;
        if (bus.cawt_full !== 1'b1) begin
            failures++;
            $display("FAIL refill_full: got %b, required 1", bus.cawt_full);
        end
        advance();
    endtask

    task automatic test_same_cycle();
        int rest[4] = '{0, 4, 6, 7};
        for (int i = 0; i < 4; i++) do_pop(i, ENTRY'(1) << i, 1'b0);
        bus.wr_req_vld = 1'b1;
        bus.ebiu_b_vld = 1'b1;
        bus.ebiu_b_id  = 3'd5;
        exp_id_q.push_back(0);
        exp_pop_q.push_back(8'b0010_0000);
        settle();
        advance();
        idle_inputs();
        // Four live entries must remain: empty only after the fourth pop.
        for (int i = 0; i < 4; i++) do_pop(rest[i], ENTRY'(1) << rest[i], (i == 3));
    endtask

    task automatic test_hits();
        bus.wr_req_vld          = 1'b1;
        bus.ca_wr_addr_hit_cawt = 8'h04;
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b0 || bus.ca_rd_stall !== 1'b0) begin
            failures++;
            $display("FAIL wr_hit: got rdy=%b rd_stall=%b, required 0 0", bus.wr_req_rdy, bus.ca_rd_stall);
        end
        advance();
        idle_inputs();
        bus.ca_rd_addr_hit_cawt = 8'h04;
        settle();
        checks++;
        if ({bus.ca_rd_stall, bus.snb0_snpext_stall, bus.snb1_snpext_stall} !== 3'b100) begin
            failures++;
            $display("FAIL rd_hit: got %b%b%b, required 100",
                     bus.ca_rd_stall, bus.snb0_snpext_stall, bus.snb1_snpext_stall);
        end
        advance();
        idle_inputs();
        bus.snb1_snpext_addr_hit_cawt = 8'h10;
        settle();
        checks++;
        if ({bus.ca_rd_stall, bus.snb0_snpext_stall, bus.snb1_snpext_stall} !== 3'b001) begin
            failures++;
            $display("FAIL snb1_hit: got %b%b%b, required 001",
                     bus.ca_rd_stall, bus.snb0_snpext_stall, bus.snb1_snpext_stall);
        end
        advance();
        idle_inputs();
        bus.snb0_snpext_addr_hit_cawt = 8'h80;
        settle();
        checks++;
        if ({bus.ca_rd_stall, bus.snb0_snpext_stall, bus.snb1_snpext_stall} !== 3'b010) begin
            failures++;
            $display("FAIL snb0_hit: got %b%b%b, required 010",
                     bus.ca_rd_stall, bus.snb0_snpext_stall, bus.snb1_snpext_stall);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_sync();
        do_write(0);
        do_write(1);
        bus.sync_req = 1'b1;
        settle();
        advance();
        bus.wr_req_vld = 1'b1;
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b0 || bus.sync_done !== 1'b0) begin
            failures++;
            $display("FAIL sync_block: got rdy=%b done=%b, required 0 0", bus.wr_req_rdy, bus.sync_done);
        end
        advance();
        do_pop(0, 8'h01, 1'b0);
        do_pop(1, 8'h02, 1'b1);
        // do_pop spent one cycle in DRAIN with cnt 0; DONE follows.
        settle();
        checks++;
        if (bus.sync_done !== 1'b1) begin
            failures++;
            $display("FAIL sync_done: got %b, required 1", bus.sync_done);
        end
        advance();
        settle();
        checks++;
        if (bus.sync_done !== 1'b0 || bus.wr_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL sync_wait: got done=%b rdy=%b, required 0 0", bus.sync_done, bus.wr_req_rdy);
        end
        advance();
        bus.sync_req = 1'b0;
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL sync_drop_rdy: got %b, required 0", bus.wr_req_rdy);
        end
        advance();
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL sync_release_rdy: got %b, required 1", bus.wr_req_rdy);
        end
        advance();
    endtask

    task automatic test_sync_empty();
        logic [2:0] seen;
        bus.sync_req = 1'b1;
        settle();
        advance();
        settle();
        seen[0] = bus.sync_done;
        advance();
        settle();
        seen[1] = bus.sync_done;
        bus.sync_req = 1'b0;
        advance();
        settle();
        seen[2] = bus.sync_done;
        checks++;
        if (seen !== 3'b010 || bus.wr_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL sync_empty: got done seq=%b rdy=%b, required 010 0", seen, bus.wr_req_rdy);
        end
        advance();
        settle();
        checks++;
        if (bus.wr_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL sync_empty_release: got %b, required 1", bus.wr_req_rdy);
        end
        advance();
    endtask

    task automatic test_bad_pop();
        do_write(0);
        do_write(1);
        bus.ebiu_b_vld = 1'b1;
        bus.ebiu_b_id  = 3'd6;
        exp_pop_q.push_back('0);
        settle();
        advance();
        idle_inputs();
        do_pop(0, 8'h01, 1'b0);
        do_pop(1, 8'h02, 1'b1);
    endtask

`ifdef EBIU_CAWT_SYNC_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_write(0);
        bus.sync_req = 1'b1;
        settle();
        advance();
        n = 0;
        while (n < 1100) begin
            settle();
            if (bus.sync_timeout === 1'b1) break;
            advance();
            n++;
        end
        checks++;
        if (n !== 1023 || bus.sync_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cycle: got n=%0d done=%b, required 1023 0", n, bus.sync_done);
        end
        advance();
        settle();
        checks++;
        if (bus.sync_done !== 1'b1 || bus.sync_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_done: got done=%b tmo=%b, required 1 0", bus.sync_done, bus.sync_timeout);
        end
        bus.sync_req = 1'b0;
        advance();
        advance();
        do_pop(0, 8'h01, 1'b1);
    endtask
`endif

    task automatic test_reset_mid();
        do_write(0);
        do_write(1);
        bus.sync_req = 1'b1;
        settle();
        advance();
        settle();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.cawt_empty !== 1'b1 || bus.cawt_full !== 1'b0 || bus.sync_done !== 1'b0 ||
            bus.wr_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: got empty=%b full=%b done=%b rdy=%b, required 1 0 0 1",
                     bus.cawt_empty, bus.cawt_full, bus.sync_done, bus.wr_req_rdy);
        end
        bus.sync_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        advance();
        do_write(0);
        settle();
        checks++;
        if (bus.cawt_empty !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_alloc: got empty=%b, required 0", bus.cawt_empty);
        end
        advance();
        do_pop(0, 8'h01, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_refill();
        test_same_cycle();
        test_hits();
        test_sync();
        test_sync_empty();
        test_bad_pop();
`ifdef EBIU_CAWT_SYNC_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        checks++;
        if (exp_id_q.size() != 0 || exp_pop_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d ids %0d pops left, required 0 0",
                     exp_id_q.size(), exp_pop_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
